coop_tx_sched: RTL

COOP_TX_SCHED -- requirements
Module: coop_tx_sched

---
 rtl/coop_pkg.sv | 25 ++
 rtl/coop_tx_sched_rr_arbiter.sv | 33 +++
 rtl/coop_tx_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/coop_pkg.sv
// Shared types and constants for the cooperative UART packet scheduler.
// Holds the FSM encoding, packet framing bytes and the hex digit encoder.
package coop_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int PKT_LEN = 8;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    // Uppercase ASCII hex digit for one nibble
    function automatic logic [7:0] hex_nibble(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

endpackage

// File: rtl/coop_tx_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last winner.
// Produces a one-hot grant, the winner index and a valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      index,
    output logic               valid
);

    logic [IW-1:0] cand;

    // First requesting slot at (last+1), (last+2), ... wraps modulo NUM_REQ
    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(last) + i) % NUM_REQ);
            if (enable && !valid && req[cand]) begin
                grant[cand] = 1'b1;
                index       = cand;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coop_tx_sched.sv
// Cooperative TX scheduler: grants one requester at a time and emits its
// packet "T:HHHH\r\n" into a UART FIFO, one byte every other cycle.
module coop_tx_sched
    import coop_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PKT_LEN = coop_pkg::PKT_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0][7:0]  tag,
    input  logic [NUM_REQ-1:0][15:0] value,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    input  logic                     tx_full,
    output logic                     wr_uart,
    output logic [7:0]               w_data
);

    localparam int IW = $clog2(NUM_REQ);

    state_t state, state_nx;

    logic [2:0]         idx;
    logic [IW-1:0]      last;
    logic [IW-1:0]      win;
    logic [7:0]         tag_q;
    logic [15:0]        val_q;
    logic [NUM_REQ-1:0] a_gnt;
    logic [IW-1:0]      a_idx;
    logic               a_vld;
    logic               last_byte;
    logic [7:0]         byte_cur;

    assign last_byte = (idx == 3'(PKT_LEN - 1));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req    (req),
        .last   (last),
        .enable (state == S_IDLE),
        .grant  (a_gnt),
        .index  (a_idx),
        .valid  (a_vld)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next state: a byte slot, then a mandatory gap cycle, per byte
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (a_vld) state_nx = S_SEND;
            S_SEND:  if (!tx_full) state_nx = S_GAP;
            S_GAP:   state_nx = last_byte ? S_IDLE : S_SEND;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs from state: busy flag and the byte at the current index
    always_comb begin
        busy = (state != S_IDLE);
        unique case (idx)
            3'd0:    byte_cur = tag_q;
            3'd1:    byte_cur = ASCII_COLON;
            3'd2:    byte_cur = hex_nibble(val_q[15:12]);
            3'd3:    byte_cur = hex_nibble(val_q[11:8]);
            3'd4:    byte_cur = hex_nibble(val_q[7:4]);
            3'd5:    byte_cur = hex_nibble(val_q[3:0]);
            3'd6:    byte_cur = ASCII_CR;
            default: byte_cur = ASCII_LF;
        endcase
    end

    // Datapath: latch winner payload, pulse grant/strobe, advance index
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            last    <= IW'(NUM_REQ - 1);
            win     <= '0;
            tag_q   <= '0;
            val_q   <= '0;
            gnt     <= '0;
            wr_uart <= 1'b0;
            w_data  <= '0;
        end else begin
            gnt     <= '0;
            wr_uart <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (a_vld) begin
                        gnt   <= a_gnt;
                        win   <= a_idx;
                        tag_q <= tag[a_idx];
                        val_q <= value[a_idx];
                        idx   <= '0;
                    end
                end
                S_SEND: begin
                    if (!tx_full) begin
                        wr_uart <= 1'b1;
                        w_data  <= byte_cur;
                    end
                end
                S_GAP: begin
                    if (last_byte) last <= win;
                    else           idx  <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
